// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse cursor tracker: clamped position accumulation, frame-synchronous
// display copy, and a one-entry click-selection buffer with a valid/ready handshake.
module mouse_cursor_tracker #(
    parameter int H_MAX  = 639,
    parameter int V_MAX  = 479,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pkt_valid,
    input  logic [8:0] i_pkt_dx,
    input  logic [8:0] i_pkt_dy,
    input  logic       i_pkt_xovf,
    input  logic       i_pkt_yovf,
    input  logic       i_pkt_left,
    input  logic       i_pkt_right,
    input  logic       i_frame_start,
    output logic [9:0] o_cur_x,
    output logic [9:0] o_cur_y,
    output logic       o_sel_valid,
    output logic       o_sel_goal,
    output logic [9:0] o_sel_x,
    output logic [9:0] o_sel_y,
    input  logic       i_sel_ready,
    output logic       o_drop_flag
);
    localparam logic signed [11:0] HMAX12 = 12'(H_MAX);
    localparam logic signed [11:0] VMAX12 = 12'(V_MAX);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    logic [9:0]         r_pos_x, r_pos_y;
    logic               r_prev_l, r_prev_r;
    state_t             r_state, w_state_nxt;
    logic signed [11:0] w_dx, w_dy, w_sum_x, w_sum_y;
    logic [9:0]         w_nxt_x, w_nxt_y;
    logic               w_rise_l, w_rise_r, w_click;

    // Overflowed packets saturate to the extreme 9-bit movement in the flagged direction.
    always_comb begin
        w_dx = i_pkt_xovf ? (i_pkt_dx[8] ? -12'sd256 : 12'sd255) : $signed({{3{i_pkt_dx[8]}}, i_pkt_dx});
        w_dy = i_pkt_yovf ? (i_pkt_dy[8] ? -12'sd256 : 12'sd255) : $signed({{3{i_pkt_dy[8]}}, i_pkt_dy});
        w_sum_x = $signed({2'b00, r_pos_x}) + w_dx;
        w_sum_y = $signed({2'b00, r_pos_y}) - w_dy;
        if (w_sum_x < 12'sd0)      w_nxt_x = '0;
        else if (w_sum_x > HMAX12) w_nxt_x = HMAX12[9:0];
        else                       w_nxt_x = w_sum_x[9:0];
        if (w_sum_y < 12'sd0)      w_nxt_y = '0;
        else if (w_sum_y > VMAX12) w_nxt_y = VMAX12[9:0];
        else                       w_nxt_y = w_sum_y[9:0];
    end

    assign w_rise_l = i_pkt_valid & i_pkt_left  & ~r_prev_l;
    assign w_rise_r = i_pkt_valid & i_pkt_right & ~r_prev_r;
    assign w_click  = w_rise_l | w_rise_r;

    // cur_* copies the pre-update position, so a same-cycle packet lands next frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos_x  <= 10'(X_INIT);
            r_pos_y  <= 10'(Y_INIT);
            o_cur_x  <= 10'(X_INIT);
            o_cur_y  <= 10'(Y_INIT);
            r_prev_l <= 1'b0;
            r_prev_r <= 1'b0;
        end else begin
            if (i_pkt_valid) begin
                r_pos_x  <= w_nxt_x;
                r_pos_y  <= w_nxt_y;
                r_prev_l <= i_pkt_left;
                r_prev_r <= i_pkt_right;
            end
            if (i_frame_start) begin
                o_cur_x <= r_pos_x;
                o_cur_y <= r_pos_y;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_click)     w_state_nxt = PEND;
            PEND: if (i_sel_ready) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_sel_valid = (r_state == PEND);
    end

    // Left wins a simultaneous rise; the lost right click, or any click while PEND, is a drop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_sel_goal  <= 1'b0;
            o_sel_x     <= '0;
            o_sel_y     <= '0;
            o_drop_flag <= 1'b0;
        end else begin
            if (r_state == IDLE && w_click) begin
                o_sel_goal <= ~w_rise_l;
                o_sel_x    <= w_nxt_x;
                o_sel_y    <= w_nxt_y;
            end
            if ((r_state == IDLE && w_rise_l && w_rise_r) || (r_state == PEND && w_click))
                o_drop_flag <= 1'b1;
        end
    end
endmodule

// File: doc/mouse_cursor_tracker.md
MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

Interface
REQ-001 The parameter H_MAX SHALL default to 639 and set the largest cursor X (pixels).
REQ-002 The parameter V_MAX SHALL default to 479 and set the largest cursor Y (pixels).
REQ-003 The parameters X_INIT and Y_INIT SHALL default to 320 and 240 and set the cursor position after reset.
REQ-004 Clk  input  1  single clock for all state; Reset  input  1  synchronous, active-high reset.
REQ-005 pkt_valid  input  1  one-cycle strobe; a decoded PS/2 mouse packet is present on the pkt_* inputs.
REQ-006 pkt_dx, pkt_dy  input  9 each  two's-complement movement; +dy means mouse moved up.
REQ-007 pkt_xovf, pkt_yovf  input  1 each  PS/2 overflow flags for X and Y.
REQ-008 pkt_left, pkt_right  input  1 each  button levels from the packet.
REQ-009 frame_start  input  1  one-cycle strobe at the start of VGA vertical blanking.
REQ-010 cur_x  output  10  cursor X for the renderer; cur_y  output  10  cursor Y for the renderer.
REQ-011 sel_valid  output  1  a click selection is pending.
REQ-012 sel_goal  output  1  0 means start node (left click), 1 means goal node (right click).
REQ-013 sel_x, sel_y  output  10 each  cursor position captured at the click.
REQ-014 sel_ready  input  1  the graph/A* stage accepts the selection.
REQ-015 drop_flag  output  1  sticky flag; a click was lost.

Function
REQ-016 The block SHALL hold the internal position pos_x and pos_y; only pkt_valid cycles change them.
REQ-017 On pkt_valid, the effective dx SHALL be pkt_dx, except when pkt_xovf=1: then +255 if pkt_dx[8]=0, else -256. pkt_dy and pkt_yovf SHALL follow the same rule.
REQ-018 The block SHALL compute next_x = pos_x + dx and next_y = pos_y - dy, using at least 12-bit signed arithmetic.
REQ-019 Results below 0 SHALL clamp to 0; results above H_MAX or V_MAX SHALL clamp to H_MAX or V_MAX; no wrap-around.
REQ-020 The new pos_x and pos_y SHALL be registered on the cycle after pkt_valid (latency 1).
REQ-021 cur_x and cur_y SHALL load from pos_x and pos_y only on a frame_start cycle. This keeps the renderer tear-free.
REQ-022 If pkt_valid and frame_start occur in the same cycle, cur_x and cur_y SHALL take the pre-update pos_x and pos_y.
REQ-023 The block SHALL register the previous pkt_left and pkt_right levels, sampled only on pkt_valid.
REQ-024 A click event SHALL be a 0->1 change of a button level between successive valid packets.
REQ-025 If both buttons rise in the same packet, the left click SHALL be taken and the right click counted as dropped.
REQ-026 The selection port SHALL be a one-entry buffer with two states, IDLE and PEND.
- IDLE: a click event captures sel_goal, sel_x and sel_y and moves to PEND. sel_x and sel_y take the clamped position produced by the same packet.
- PEND: sel_valid=1, and sel_goal, sel_x and sel_y are held stable. sel_valid & sel_ready returns to IDLE on the next cycle.
REQ-027 A click event that occurs in PEND SHALL be discarded and SHALL set drop_flag. This includes the cycle where sel_ready is high.
REQ-028 drop_flag SHALL clear only on Reset.
REQ-029 sel_ready SHALL be ignored in IDLE.
REQ-030 sel_valid SHALL never deassert without the handshake, except on Reset.
REQ-031 pkt_* inputs SHALL be ignored when pkt_valid=0.

Reset
REQ-032 On Reset=1 at a Clk edge:
- pos_x, pos_y, cur_x, cur_y load X_INIT, Y_INIT.
- The selection state goes to IDLE; sel_valid, sel_goal, sel_x, sel_y = 0.
- drop_flag = 0; the previous-button registers = 0.
REQ-033 Reset SHALL take priority over every simultaneous event, including a mid-handshake PEND state. A pending selection SHALL be discarded.

Verification
REQ-034 Motion and display update: reset, then pkt dx=+10, dy=+5 -> pos (330,235) next cycle; cur_x and cur_y stay (320,240) until frame_start, then read (330,235).
REQ-035 Clamping: pos (5,470), pkt dx=-20, dy=-30 -> (0,479); from (630,5), pkt xovf=1 dx=+1 and dy=+8 -> (639,0).
REQ-036 Click handshake: pkt left=1 at pos (100,200) -> sel_valid=1, sel_goal=0, sel (100,200); hold sel_ready=0 for 5 cycles -> outputs stable; pulse sel_ready -> sel_valid=0 next cycle.
REQ-037 Drop: while PEND, a packet with right rising -> drop_flag=1 and sel fields unchanged; a repeat of left=1 with left already high -> no new event.
REQ-038 Simultaneous and reset: left and right rise together -> sel_goal=0 and drop_flag=1; assert Reset while PEND -> sel_valid=0, drop_flag=0, cur (320,240).
